pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Program-counter and next-PC stage for the single-cycle RISC-V core. It sits directly upstream of the instruction memory. It owns the architectural PC and selects the next PC each cycle from sequential, branch and JALR sources. It also detects misaligned or out-of-range fetch targets and redirects them to a trap vector, and it halts the core on an ECALL/EBREAK request. It drives the byte address and the word index that the instruction memory reads.

## Interface
Parameters:
- `RESET_VECTOR`, default 32'h0000_0000: PC value loaded by reset.
- `TRAP_VECTOR`, default 32'h0000_0100: PC value loaded on a fetch fault.
- `IMEM_AW`, default 10: log2 of the instruction-memory depth in words (1024 words).

Ports (the clock is `clk`; reset is synchronous and active-high, named `rst`):
- `clk` in 1: core clock. All state updates on the rising edge.
- `rst` in 1: synchronous active-high reset.
- `stall` in 1: freezes PC, FSM and counter for this cycle.
- `pc_src` in 2: next-PC select. 00 = PC+4, 01 = branch (PC+imm_ext), 10 = JALR ((rs1_data+imm_ext) & ~1), 11 = PC+4.
- `imm_ext` in 32: sign-extended immediate from the decoder.
- `rs1_data` in 32: register-file rs1 read data.
- `halt_req` in 1: the current instruction is ECALL/EBREAK.
- `PC_out_address` out 32: current PC as a byte address.
- `imem_word_index` out IMEM_AW: PC_out_address[IMEM_AW+1:2].
- `pc_plus4` out 32: PC+4, used for the JAL/JALR link value.
- `pc_valid` out 1: high when the current instruction must be executed (state RUN).
- `trap` out 1: one-cycle pulse on a fetch fault.
- `trap_cause` out 2: 00 = none, 01 = misaligned target, 10 = out-of-range target. Held until the next fault or reset.
- `trap_epc` out 32: PC of the instruction whose target faulted. Held until the next fault or reset.
- `halted` out 1: high in state HALT.
- `retired_count` out 64: count of retired instructions.

## Operation
- The FSM has four states: BOOT, RUN, TRAP, HALT.
- Reset sets PC=RESET_VECTOR, state=BOOT, trap=0, trap_cause=00, trap_epc=0, retired_count=0.
  - While rst is high or the state is BOOT: pc_valid=0 and halted=0.
- BOOT goes to RUN after exactly one cycle. PC does not change during BOOT.
- RUN uses the following priority, first match wins:
  1. `stall`: hold everything.
  2. `halt_req`: go to HALT; PC holds; retired_count increments by 1.
  3. Target fault, where target is the value selected by pc_src:
     - a fault exists if target[1:0]≠0 (misaligned, cause 01), else if target[31:IMEM_AW+2]≠0 (out of range, cause 10);
     - on a fault: PC←TRAP_VECTOR, trap_epc←PC, trap_cause←cause, trap=1 for this cycle, state←TRAP;
     - the faulting instruction is not counted.
  4. Otherwise: PC←target and retired_count increments by 1.
- TRAP: pc_valid=0 for one cycle, then go to RUN. `stall` is ignored in TRAP.
- HALT: pc_valid=0 and halted=1. PC holds. Only rst leaves HALT.
- Arithmetic:
  - All adds are 32-bit modulo 2^32, so wrap-around is silent.
  - Any target that wraps is then checked by the range rule.
  - The JALR target has bit 0 cleared before the alignment check. JALR therefore faults only on bit 1.
- retired_count is 64-bit and wraps from all-ones to 0.

## Timing
- PC_out_address, imem_word_index and pc_plus4 are combinational from the PC register. They are valid during the same cycle the PC is held.
- Inputs are sampled on the rising edge. The new PC is visible one cycle after the selecting edge.
- `trap` is registered: it is high for the first cycle of TRAP, together with pc_valid=0.
- If rst is asserted mid-operation, including in TRAP or HALT, the block returns to the reset values on the next edge.
- If stall and halt_req are high together, stall wins. halt_req must be re-presented in a later cycle.
- If stall and a faulting target occur together, no trap is taken.

## Test plan
- Reset and sequential fetch: rst for 2 cycles, then pc_src=00 for 4 cycles.
  - Required: BOOT for 1 cycle, then PC = 0, 4, 8, 12.
  - imem_word_index = 0, 1, 2, 3; retired_count=4.
- Branch and JALR: at PC=8, pc_src=01 with imm_ext=32'hFFFF_FFF8 → PC=0.
  - Then pc_src=10 with rs1_data=32'h41 and imm_ext=3 → PC=32'h44 (bit 0 cleared), no trap.
- Misaligned fault: at PC=32'h10, pc_src=10, rs1_data=32'h12, imm_ext=0.
  - Required: trap pulse, trap_cause=01, trap_epc=32'h10, PC=32'h100.
  - pc_valid=0 for one cycle, then RUN resumes at 32'h100; retired_count unchanged.
- Out-of-range fault: pc_src=01 with imm_ext=32'h0000_1000 from PC=0 → trap_cause=10 and PC=32'h100.
- Stall and halt priority: stall=1 with halt_req=1 for 3 cycles → PC, state and count unchanged.
  - Then stall=0 and halt_req=1 → halted=1, count+1.
  - Further pc_src activity has no effect; rst returns PC to 0.
- Reset mid-TRAP: assert rst in the TRAP cycle → all outputs return to reset values on the next edge, and trap_cause=00.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// ============================================================================
// pc_fetch_unit : architectural PC, next-PC select, fetch-fault trap, halt.
// Rev 1.0
// ============================================================================
`default_nettype none

module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int          IMEM_AW      = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic [1:0]         pc_src,
  input  logic [31:0]        imm_ext,
  input  logic [31:0]        rs1_data,
  input  logic               halt_req,
  output logic [31:0]        PC_out_address,
  output logic [IMEM_AW-1:0] imem_word_index,
  output logic [31:0]        pc_plus4,
  output logic               pc_valid,
  output logic               trap,
  output logic [1:0]         trap_cause,
  output logic [31:0]        trap_epc,
  output logic               halted,
  output logic [63:0]        retired_count
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2,
    HALT = 2'd3
  } state_t;

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_ALIGN = 2'b01;
  localparam logic [1:0] CAUSE_RANGE = 2'b10;

  state_t      state_q;
  logic [31:0] pc_q;
  logic        trap_q;
  logic [1:0]  trap_cause_q;
  logic [31:0] trap_epc_q;
  logic [63:0] retired_q;

  logic [31:0] target_d;
  logic [1:0]  fault_cause_d;

  always_comb begin
    target_d      = pc_q + 32'd4;
    fault_cause_d = CAUSE_NONE;
    case (pc_src)
      2'b01:   target_d = pc_q + imm_ext;
      2'b10:   target_d = (rs1_data + imm_ext) & 32'hFFFF_FFFE;
      default: target_d = pc_q + 32'd4;
    endcase
    // Alignment takes precedence over range; wrapped targets land in the range check.
    if (target_d[1:0] != 2'b00) begin
      fault_cause_d = CAUSE_ALIGN;
    end else if ((target_d >> (IMEM_AW + 2)) != 32'd0) begin
      fault_cause_d = CAUSE_RANGE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= BOOT;
      pc_q         <= RESET_VECTOR;
      trap_q       <= 1'b0;
      trap_cause_q <= CAUSE_NONE;
      trap_epc_q   <= 32'd0;
      retired_q    <= 64'd0;
    end else begin
      trap_q <= 1'b0;
      case (state_q)
        BOOT: state_q <= RUN;
        RUN: begin
          if (stall) begin
            state_q <= RUN;
          end else if (halt_req) begin
            state_q   <= HALT;
            retired_q <= retired_q + 64'd1;
          end else if (fault_cause_d != CAUSE_NONE) begin
            state_q      <= TRAP;
            pc_q         <= TRAP_VECTOR;
            trap_epc_q   <= pc_q;
            trap_cause_q <= fault_cause_d;
            trap_q       <= 1'b1;
          end else begin
            pc_q      <= target_d;
            retired_q <= retired_q + 64'd1;
          end
        end
        TRAP:    state_q <= RUN;
        default: state_q <= HALT;
      endcase
    end
  end

  assign PC_out_address  = pc_q;
  assign imem_word_index = pc_q[IMEM_AW+1:2];
  assign pc_plus4        = pc_q + 32'd4;
  assign pc_valid        = (state_q == RUN) && !rst;
  assign halted          = (state_q == HALT) && !rst;
  assign trap            = trap_q;
  assign trap_cause      = trap_cause_q;
  assign trap_epc        = trap_epc_q;
  assign retired_count   = retired_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
// ============================================================================
// tb_pc_fetch_unit : directed scoreboard bench for pc_fetch_unit.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pc_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic [1:0]  pc_src;
  logic [31:0] imm_ext;
  logic [31:0] rs1_data;
  logic        halt_req;
  logic [31:0] PC_out_address;
  logic [9:0]  imem_word_index;
  logic [31:0] pc_plus4;
  logic        pc_valid;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [31:0] trap_epc;
  logic        halted;
  logic [63:0] retired_count;

  pc_fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .pc_src          (pc_src),
    .imm_ext         (imm_ext),
    .rs1_data        (rs1_data),
    .halt_req        (halt_req),
    .PC_out_address  (PC_out_address),
    .imem_word_index (imem_word_index),
    .pc_plus4        (pc_plus4),
    .pc_valid        (pc_valid),
    .trap            (trap),
    .trap_cause      (trap_cause),
    .trap_epc        (trap_epc),
    .halted          (halted),
    .retired_count   (retired_count)
  );

  typedef struct {
    int          step;
    logic [31:0] pc;
    logic        valid;
    logic        trp;
    logic [1:0]  cause;
    logic [31:0] epc;
    logic        hlt;
    logic [63:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   step_no = 0;
  bit   stim_done = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int stp, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL step %0d %s: got %0h expected %0h", stp, name, act, exp);
  endtask

  // Drive one cycle of stimulus and record the state expected after the edge.
  task automatic step(input logic r, input logic s, input logic [1:0] src,
                      input logic [31:0] imm, input logic [31:0] rs1, input logic h,
                      input logic [31:0] e_pc, input logic e_valid, input logic e_trap,
                      input logic [1:0] e_cause, input logic [31:0] e_epc,
                      input logic e_halt, input logic [63:0] e_cnt);
    exp_t e;
    @(negedge clk);
    rst = r; stall = s; pc_src = src; imm_ext = imm; rs1_data = rs1; halt_req = h;
    step_no++;
    e.step = step_no; e.pc = e_pc; e.valid = e_valid; e.trp = e_trap;
    e.cause = e_cause; e.epc = e_epc; e.hlt = e_halt; e.cnt = e_cnt;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc",         e.step, {32'd0, PC_out_address},  {32'd0, e.pc});
        chk("word_index", e.step, {54'd0, imem_word_index}, {54'd0, e.pc[11:2]});
        chk("pc_plus4",   e.step, {32'd0, pc_plus4},        {32'd0, e.pc + 32'd4});
        chk("pc_valid",   e.step, {63'd0, pc_valid},        {63'd0, e.valid});
        chk("trap",       e.step, {63'd0, trap},            {63'd0, e.trp});
        chk("trap_cause", e.step, {62'd0, trap_cause},      {62'd0, e.cause});
        chk("trap_epc",   e.step, {32'd0, trap_epc},        {32'd0, e.epc});
        chk("halted",     e.step, {63'd0, halted},          {63'd0, e.hlt});
        chk("retired",    e.step, retired_count,            e.cnt);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: bench did not finish, time %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    rst = 1'b1; stall = 1'b0; pc_src = 2'b00; imm_ext = 32'd0; rs1_data = 32'd0; halt_req = 1'b0;
    //     rst s  src    imm            rs1            h   pc            v  t  cause  epc        hlt cnt
    step(1, 0, 2'b00, 32'd0,         32'd0,         0, 32'h0000_0000, 0, 0, 2'd0, 32'h00, 0, 64'd0);
    step(1, 0, 2'b00, 32'd0,         32'd0,         0, 32'h0000_0000, 0, 0, 2'd0, 32'h00, 0, 64'd0);
    step(0, 0, 2'b00, 32'd0,         32'd0,         0, 32'h0000_0000, 1, 0, 2'd0, 32'h00, 0, 64'd0);
    step(0, 0, 2'b00, 32'd0,         32'd0,         0, 32'h0000_0004, 1, 0, 2'd0, 32'h00, 0, 64'd1);
    step(0, 0, 2'b00, 32'd0,         32'd0,         0, 32'h0000_0008, 1, 0, 2'd0, 32'h00, 0, 64'd2);
    step(0, 0, 2'b00, 32'd0,         32'd0,         0, 32'h0000_000C, 1, 0, 2'd0, 32'h00, 0, 64'd3);
    step(0, 0, 2'b00, 32'd0,         32'd0,         0, 32'h0000_0010, 1, 0, 2'd0, 32'h00, 0, 64'd4);
    // branch back to 8 then to 0, JALR to 0x44
    step(0, 0, 2'b01, 32'hFFFF_FFF8, 32'd0,         0, 32'h0000_0008, 1, 0, 2'd0, 32'h00, 0, 64'd5);
    step(0, 0, 2'b01, 32'hFFFF_FFF8, 32'd0,         0, 32'h0000_0000, 1, 0, 2'd0, 32'h00, 0, 64'd6);
    step(0, 0, 2'b10, 32'd3,         32'h41,        0, 32'h0000_0044, 1, 0, 2'd0, 32'h00, 0, 64'd7);
    step(0, 0, 2'b01, 32'hFFFF_FFCC, 32'd0,         0, 32'h0000_0010, 1, 0, 2'd0, 32'h00, 0, 64'd8);
    // misaligned JALR from 0x10; stall is ignored in TRAP
    step(0, 0, 2'b10, 32'd0,         32'h12,        0, 32'h0000_0100, 0, 1, 2'd1, 32'h10, 0, 64'd8);
    step(0, 1, 2'b01, 32'd2,         32'd0,         0, 32'h0000_0100, 1, 0, 2'd1, 32'h10, 0, 64'd8);
    step(0, 0, 2'b00, 32'd0,         32'd0,         0, 32'h0000_0104, 1, 0, 2'd1, 32'h10, 0, 64'd9);
    // out-of-range branch from PC=0
    step(0, 0, 2'b10, 32'd0,         32'd0,         0, 32'h0000_0000, 1, 0, 2'd1, 32'h10, 0, 64'd10);
    step(0, 0, 2'b01, 32'h0000_1000, 32'd0,         0, 32'h0000_0100, 0, 1, 2'd2, 32'h00, 0, 64'd10);
    step(0, 0, 2'b00, 32'd0,         32'd0,         0, 32'h0000_0100, 1, 0, 2'd2, 32'h00, 0, 64'd10);
    // stall masks a faulting target
    step(0, 1, 2'b01, 32'h0000_1000, 32'd0,         0, 32'h0000_0100, 1, 0, 2'd2, 32'h00, 0, 64'd10);
    // wrap-around: to 0 (legal), via JALR to 4 (legal), then to 0xFFFFFFF4 (range fault)
    step(0, 0, 2'b01, 32'hFFFF_FF00, 32'd0,         0, 32'h0000_0000, 1, 0, 2'd2, 32'h00, 0, 64'd11);
    step(0, 0, 2'b10, 32'd8,         32'hFFFF_FFFC, 0, 32'h0000_0004, 1, 0, 2'd2, 32'h00, 0, 64'd12);
    step(0, 0, 2'b01, 32'hFFFF_FFF0, 32'd0,         0, 32'h0000_0100, 0, 1, 2'd2, 32'h04, 0, 64'd12);
    step(0, 0, 2'b00, 32'd0,         32'd0,         0, 32'h0000_0100, 1, 0, 2'd2, 32'h04, 0, 64'd12);
    // pc_src=11 is PC+4; JALR clears bit 0 of 0x41
    step(0, 0, 2'b11, 32'h0000_0040, 32'd0,         0, 32'h0000_0104, 1, 0, 2'd2, 32'h04, 0, 64'd13);
    step(0, 0, 2'b10, 32'd0,         32'h41,        0, 32'h0000_0040, 1, 0, 2'd2, 32'h04, 0, 64'd14);
    // stall beats halt_req for 3 cycles, then halt
    for (int i = 0; i < 3; i++)
      step(0, 1, 2'b01, 32'd8,       32'd0,         1, 32'h0000_0040, 1, 0, 2'd2, 32'h04, 0, 64'd14);
    step(0, 0, 2'b01, 32'd8,         32'd0,         1, 32'h0000_0040, 0, 0, 2'd2, 32'h04, 1, 64'd15);
    step(0, 0, 2'b01, 32'd8,         32'd0,         0, 32'h0000_0040, 0, 0, 2'd2, 32'h04, 1, 64'd15);
    step(0, 0, 2'b10, 32'd0,         32'h80,        0, 32'h0000_0040, 0, 0, 2'd2, 32'h04, 1, 64'd15);
    step(1, 0, 2'b00, 32'd0,         32'd0,         0, 32'h0000_0000, 0, 0, 2'd0, 32'h00, 0, 64'd0);
    // reset asserted during the TRAP cycle
    step(0, 0, 2'b00, 32'd0,         32'd0,         0, 32'h0000_0000, 1, 0, 2'd0, 32'h00, 0, 64'd0);
    step(0, 0, 2'b01, 32'd2,         32'd0,         0, 32'h0000_0100, 0, 1, 2'd1, 32'h00, 0, 64'd0);
    step(1, 0, 2'b00, 32'd0,         32'd0,         0, 32'h0000_0000, 0, 0, 2'd0, 32'h00, 0, 64'd0);
    step(0, 0, 2'b00, 32'd0,         32'd0,         0, 32'h0000_0000, 1, 0, 2'd0, 32'h00, 0, 64'd0);
    step(0, 0, 2'b00, 32'd0,         32'd0,         0, 32'h0000_0004, 1, 0, 2'd0, 32'h00, 0, 64'd1);
    @(posedge clk);
    #3;
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    stim_done = 1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
